// File: rtl/rst_seq_if.sv
// Reset-sequencer request/reset bundle: software and watchdog requests in,
// staged subsystem resets, busy flag and last-reset cause out.
interface rst_seq_if;
  logic       swrst_req;
  logic       wdt_req;
  logic       rst_mem_n;
  logic       rst_core_n;
  logic       rst_periph_n;
  logic       seq_busy;
  logic [1:0] rst_cause;

  modport master (
    output swrst_req,
    output wdt_req,
    input  rst_mem_n,
    input  rst_core_n,
    input  rst_periph_n,
    input  seq_busy,
    input  rst_cause
  );

  modport slave (
    input  swrst_req,
    input  wdt_req,
    output rst_mem_n,
    output rst_core_n,
    output rst_periph_n,
    output seq_busy,
    output rst_cause
  );
endinterface

// File: rtl/rst_seq.sv
// Reset sequencer: holds all subsystem resets, releases mem -> core -> periph,
// and replays the sequence after an accepted software or watchdog request.
module rst_seq #(
  parameter int unsigned HOLD_CYC  = 16,
  parameter int unsigned STEP_CYC  = 4,
  parameter int unsigned SWRST_CYC = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rst_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    StHold,
    StRelMem,
    StRelCore,
    StRun,
    StAssert
  } state_e;

  localparam logic [1:0] CausePor = 2'b00;
  localparam logic [1:0] CauseSw  = 2'b01;
  localparam logic [1:0] CauseWdt = 2'b10;

  // Terminal values: the counter is cleared on entry, so the Nth edge in a state sees N-1.
  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] StepLast  = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] SwrstLast = CNT_W'(SWRST_CYC - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_n;
  logic             r_core_n;
  logic             r_periph_n;
  logic             r_busy;
  logic [1:0]       r_cause;
  logic             w_req;

  assign w_req = bus.swrst_req | bus.wdt_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StHold;
      r_cnt      <= '0;
      r_mem_n    <= 1'b0;
      r_core_n   <= 1'b0;
      r_periph_n <= 1'b0;
      r_busy     <= 1'b1;
      r_cause    <= CausePor;
    end else begin
      unique case (r_state)
        StHold: begin
          if (r_cnt == HoldLast) begin
            r_mem_n <= 1'b1;
            r_cnt   <= '0;
            r_state <= StRelMem;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StRelMem: begin
          if (r_cnt == StepLast) begin
            r_core_n <= 1'b1;
            r_cnt    <= '0;
            r_state  <= StRelCore;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StRelCore: begin
          if (r_cnt == StepLast) begin
            r_periph_n <= 1'b1;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_state    <= StRun;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StRun: begin
          r_cnt <= '0;
          if (w_req) begin
            r_mem_n    <= 1'b0;
            r_core_n   <= 1'b0;
            r_periph_n <= 1'b0;
            r_busy     <= 1'b1;
            r_cause    <= bus.wdt_req ? CauseWdt : CauseSw;
            r_state    <= StAssert;
          end
        end
        StAssert: begin
          if (r_cnt == SwrstLast) begin
            r_cnt   <= '0;
            r_state <= StHold;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= StHold;
          r_cnt      <= '0;
          r_mem_n    <= 1'b0;
          r_core_n   <= 1'b0;
          r_periph_n <= 1'b0;
          r_busy     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rst_mem_n    = r_mem_n;
  assign bus.rst_core_n   = r_core_n;
  assign bus.rst_periph_n = r_periph_n;
  assign bus.seq_busy     = r_busy;
  assign bus.rst_cause    = r_cause;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed and random request/reset stimulus checked every
// cycle against a timeline model (edges since sequence start).
module tb_rst_seq;

  localparam int HOLD = 16;
  localparam int STEP = 4;
  localparam int SW   = 8;
  localparam int REL_PERIPH = HOLD + 2 * STEP;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  rst_seq_if bus ();

  rst_seq #(
    .HOLD_CYC  (HOLD),
    .STEP_CYC  (STEP),
    .SWRST_CYC (SW),
    .CNT_W     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc;      // edges since rst_n release
  int         m_start;  // edge 0 of the current release sequence
  logic [1:0] m_cause;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    int k;
    logic [3:0] e;
    k    = cyc - m_start;
    e[3] = (k >= HOLD);
    e[2] = (k >= HOLD + STEP);
    e[1] = (k >= REL_PERIPH);
    e[0] = !(k >= REL_PERIPH);
    check("resets_busy", {bus.rst_mem_n, bus.rst_core_n, bus.rst_periph_n, bus.seq_busy}, e);
    check("rst_cause", {2'b00, bus.rst_cause}, {2'b00, m_cause});
  endtask

  // One clock edge with the given request levels; the model accepts a request
  // only if periph was already released before this edge.
  task automatic step(input logic sw, input logic wdt);
    bus.swrst_req = sw;
    bus.wdt_req   = wdt;
    @(posedge clk);
    cyc++;
    if ((sw || wdt) && (cyc - 1 - m_start >= REL_PERIPH)) begin
      m_start = cyc + SW;
      m_cause = wdt ? 2'b10 : 2'b01;
    end
    #1;
    check_all();
  endtask

  task automatic por(input int n);
    bus.swrst_req = 1'b0;
    bus.wdt_req   = 1'b0;
    rst_n   = 1'b0;
    m_cause = 2'b00;
    #1;
    check("async_assert", {bus.rst_mem_n, bus.rst_core_n, bus.rst_periph_n, bus.seq_busy},
          4'b0001);
    check("async_cause", {2'b00, bus.rst_cause}, 4'b0000);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("in_reset", {bus.rst_mem_n, bus.rst_core_n, bus.rst_periph_n, bus.seq_busy},
            4'b0001);
    end
    rst_n   = 1'b1;
    cyc     = 0;
    m_start = 0;
  endtask

  initial begin
    bus.swrst_req = 1'b0;
    bus.wdt_req   = 1'b0;
    #2;
    // POR: 16/20/24
    por(5);
    repeat (30) step(1'b0, 1'b0);
    // Software pulse in RUN
    step(1'b1, 1'b0);
    repeat (35) step(1'b0, 1'b0);
    // Tie: watchdog wins
    step(1'b1, 1'b1);
    repeat (35) step(1'b0, 1'b0);
    // Request at edge 18 of POR and watchdog during ASSERT are ignored
    por(3);
    repeat (17) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (40) step(1'b0, 1'b0);
    // rst_n asserted at E+3 during ASSERT
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    por(4);
    repeat (30) step(1'b0, 1'b0);
    // Request held high: period 33
    repeat (80) step(1'b1, 1'b0);
    // Random requests with occasional global reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        por(int'($urandom_range(1, 4)));
      end else begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
